// File: rtl/radix4_booth_mult_param.sv
// Sequential radix-4 Booth multiplier, signed or unsigned operands, one Booth digit per clock.
// Flow: IDLE -> LOAD -> ITER (N cycles) -> DONE, with back-to-back restart from DONE.
module radix4_booth_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           state
);

  localparam int AW = 2*WIDTH + 2;
  localparam int MW = WIDTH + 3;
  localparam int CW = $clog2(WIDTH/2 + 2);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    DONE = 3'd3
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_signed;
  logic [AW-1:0]      r_accum;
  logic [AW-1:0]      r_mcand;
  logic [MW-1:0]      r_mplr;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_product;

  logic               w_accept;
  logic               w_lastIter;
  logic               w_aExt;
  logic               w_bExt;
  logic [AW-1:0]      w_partial;
  logic [AW-1:0]      w_accumNext;

  assign w_accept    = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_lastIter  = (r_state == ITER) && (r_count == CW'(1));
  assign w_aExt      = r_signed & r_a[WIDTH-1];
  assign w_bExt      = r_signed & r_b[WIDTH-1];
  assign w_accumNext = r_accum + w_partial;

  // Booth digit from the low three multiplier bits; r_mcand already carries the weight.
  always_comb begin
    w_partial = '0;
    case (r_mplr[2:0])
      3'b001, 3'b010: w_partial = r_mcand;
      3'b011:         w_partial = r_mcand << 1;
      3'b100:         w_partial = -(r_mcand << 1);
      3'b101, 3'b110: w_partial = -r_mcand;
      default:        w_partial = '0;
    endcase
  end

  always_comb begin
    w_nextState = IDLE;
    case (r_state)
      IDLE:    w_nextState = start ? LOAD : IDLE;
      LOAD:    w_nextState = ITER;
      ITER:    w_nextState = w_lastIter ? DONE : ITER;
      DONE:    w_nextState = start ? LOAD : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_signed  <= 1'b0;
      r_accum   <= '0;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_a      <= a;
        r_b      <= b;
        r_signed <= signed_mode;
      end
      // Unsigned needs one extra digit so the zero-extended top bits get consumed.
      if (r_state == LOAD) begin
        r_accum <= '0;
        r_mplr  <= {{2{w_bExt}}, r_b, 1'b0};
        r_mcand <= {{(AW-WIDTH){w_aExt}}, r_a};
        r_count <= r_signed ? CW'(WIDTH/2) : CW'(WIDTH/2 + 1);
      end
      if (r_state == ITER) begin
        r_accum <= w_accumNext;
        r_mplr  <= {{2{r_mplr[MW-1]}}, r_mplr[MW-1:2]};
        r_mcand <= r_mcand << 2;
        r_count <= r_count - 1'b1;
      end
      if (w_lastIter) begin
        r_product <= w_accumNext[2*WIDTH-1:0];
      end
    end
  end

  assign product = r_product;
  assign state   = r_state;
  assign busy    = (r_state == LOAD) || (r_state == ITER);
  assign done    = (r_state == DONE);

endmodule

// File: tb/tb_radix4_booth_mult_param.sv
// Directed testbench for radix4_booth_mult_param at WIDTH=8.
// Expected products and latencies are hand-computed constants.
module tb_radix4_booth_mult_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signedMode;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] product;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  radix4_booth_mult_param #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signedMode),
    .a           (a),
    .b           (b),
    .product     (product),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One-cycle start pulse; returns just after the start-sampling edge (edge 1).
  task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB, input logic mode);
    @(negedge clk);
    a          = opA;
    b          = opB;
    signedMode = mode;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts rising edges (start edge = 1) until done is seen at a falling edge.
  task automatic waitDone(input string tag, output int edges);
    edges = 1;
    @(negedge clk);
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (done !== 1'b1) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic runCase(input string tag, input logic [7:0] opA, input logic [7:0] opB,
                         input logic mode, input logic [15:0] expProduct, input int expEdges);
    int edges;
    applyStimulus(opA, opB, mode);
    waitDone(tag, edges);
    checkOutput({tag, "_product"}, 32'(product), 32'(expProduct));
    checkOutput({tag, "_latency"}, 32'(edges), 32'(expEdges));
    @(posedge clk);
    #1 checkOutput({tag, "_donePulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_idle"}, 32'(state), 32'd0);
  endtask

  initial begin
    int edges;
    int extraDone;
    rst        = 1'b0;
    start      = 1'b0;
    signedMode = 1'b0;
    a          = '0;
    b          = '0;
    #12;
    checkOutput("reset_state",   32'(state),   32'd0);
    checkOutput("reset_product", 32'(product), 32'd0);
    checkOutput("reset_busy",    32'(busy),    32'd0);
    checkOutput("reset_done",    32'(done),    32'd0);
    @(negedge clk);
    rst = 1'b1;

    runCase("u68x35",   8'd68,  8'd35,  1'b0, 16'h094C, 7);
    runCase("s80x80",   8'h80,  8'h80,  1'b1, 16'h4000, 6);
    runCase("sFFx7F",   8'hFF,  8'h7F,  1'b1, 16'hFF81, 6);
    runCase("uFFxFF",   8'hFF,  8'hFF,  1'b0, 16'hFE01, 7);
    runCase("sFFxFF",   8'hFF,  8'hFF,  1'b1, 16'h0001, 6);
    runCase("s7Fx80",   8'h7F,  8'h80,  1'b1, 16'hC080, 6);

    // Inputs and start toggled mid-ITER must not disturb the original operation.
    applyStimulus(8'd12, 8'd10, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("ignore_busy", 32'(busy), 32'd1);
    a          = 8'd99;
    b          = 8'd77;
    signedMode = 1'b1;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 0;
    waitDone("ignore", edges);
    checkOutput("ignore_product", 32'(product), 32'h0078);
    extraDone = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (done) extraDone++;
    end
    checkOutput("ignore_extraDone", 32'(extraDone), 32'd0);
    checkOutput("ignore_hold",      32'(product),   32'h0078);

    // Back-to-back: start held through DONE captures the new operands.
    applyStimulus(8'd7, 8'd9, 1'b0);
    waitDone("b2b_first", edges);
    checkOutput("b2b_firstProduct", 32'(product), 32'h003F);
    a          = 8'd3;
    b          = 8'd5;
    signedMode = 1'b0;
    start      = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("b2b_load",        32'(state),   32'd1);
    checkOutput("b2b_productHeld", 32'(product), 32'h003F);
    start = 1'b0;
    waitDone("b2b_second", edges);
    checkOutput("b2b_secondProduct", 32'(product), 32'h000F);

    // Asynchronous reset in the middle of ITER.
    applyStimulus(8'd68, 8'd35, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midReset_state",   32'(state),   32'd0);
    checkOutput("midReset_product", 32'(product), 32'd0);
    checkOutput("midReset_busy",    32'(busy),    32'd0);
    checkOutput("midReset_done",    32'(done),    32'd0);
    @(negedge clk);
    rst = 1'b1;
    extraDone = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (done) extraDone++;
    end
    checkOutput("midReset_noDone", 32'(extraDone), 32'd0);

    // Start accepted on the very first edge after reset release.
    rst = 1'b0;
    @(negedge clk);
    rst        = 1'b1;
    a          = 8'd3;
    b          = 8'd5;
    signedMode = 1'b0;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("firstEdge_load", 32'(state), 32'd1);
    waitDone("firstEdge", edges);
    checkOutput("firstEdge_product", 32'(product), 32'h000F);
    checkOutput("firstEdge_latency", 32'(edges),   32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
